// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   Steps a digit index through the enabled digits. Each digit is lit for
//   SCAN_DIV cycles and then followed by BLANK_CYC dark cycles. The index,
//   the one-hot digit select and the digit's 4-bit value are presented to the
//   segment encoder. New content is staged in shadow registers and only
//   becomes active on a frame boundary, so a frame never shows mixed data.
//
// Parameters
//   SCAN_DIV     lit cycles per digit (>= 1)
//   BLANK_CYC    dark cycles after each digit (0 = no blanking)
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   en_i          scan enable; low forces idle
//   dig_en_i[7:0] per-digit enable mask (staged by load_i)
//   data_i[31:0]  digit values, digit i = data_i[4i+3:4i] (staged by load_i)
//   load_i        strobe that captures data_i/dig_en_i into the shadow regs
//   sel_o[2:0]    current digit index (0 when idle)
//   dig_o[7:0]    one-hot digit select, 0 when nothing is lit
//   nib_o[3:0]    value of the lit digit, 0 when nothing is lit
//   frame_done_o  one-cycle pulse after the last lit cycle of a frame
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  dig_en_i,
  input  logic [31:0] data_i,
  input  logic        load_i,
  output logic [2:0]  sel_o,
  output logic [7:0]  dig_o,
  output logic [3:0]  nib_o,
  output logic        frame_done_o
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   actData_q, actData_d;
  logic [7:0]    actMask_q, actMask_d;
  logic [31:0]   shData_q;
  logic [7:0]    shMask_q;
  logic          pend_q, pend_d;
  logic [2:0]    selOut_q;
  logic [7:0]    digOut_q;
  logic [3:0]    nibOut_q;
  logic          frameDone_q;

  logic [31:0]   rlData;
  logic [7:0]    rlMask;
  logic          wrap;
  logic          advance;

  // Lowest enabled digit of a mask (0 for an empty mask).
  function automatic logic [2:0] lowestBit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Nearest enabled digit strictly above s (0 if there is none).
  function automatic logic [2:0] nextAbove(input logic [7:0] m, input logic [2:0] s);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) r = 3'(i);
    end
    return r;
  endfunction

  // True when some enabled digit lies above s.
  function automatic logic hasAbove(input logic [7:0] m, input logic [2:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && (i > int'(s))) r = 1'b1;
    end
    return r;
  endfunction

  // A load in the same cycle as a reload bypasses the shadow registers so the
  // freshest content is taken.
  assign rlData = load_i ? data_i   : shData_q;
  assign rlMask = load_i ? dig_en_i : shMask_q;
  assign wrap   = !hasAbove(actMask_q, idx_q);

  // Shadow registers: staged content, written on every load strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shData_q <= 32'h0;
      shMask_q <= 8'hFF;
    end else if (load_i) begin
      shData_q <= data_i;
      shMask_q <= dig_en_i;
    end
  end

  // Scan state: FSM state, cycle counter, digit index, active content and the
  // frame-end flag raised when the last digit of a frame finishes its lit time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      actData_q <= 32'h0;
      actMask_q <= 8'h0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      actData_q <= actData_d;
      actMask_q <= actMask_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state logic. Leaving the last digit of the mask is a frame boundary:
  // active content is reloaded and an empty reloaded mask parks the scan idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    actData_d = actData_q;
    actMask_d = actMask_q;
    pend_d    = 1'b0;
    advance   = 1'b0;

    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rlMask != 8'h0) begin
            actData_d = rlData;
            actMask_d = rlMask;
            idx_d     = lowestBit(rlMask);
            cnt_d     = '0;
            state_d   = ON;
          end
        end
        ON: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_d  = '0;
            pend_d = wrap;
            if (BLANK_CYC == 0) begin
              advance = 1'b1;
            end else begin
              state_d = BLANK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      endcase

      if (advance) begin
        if (wrap) begin
          actData_d = rlData;
          actMask_d = rlMask;
          if (rlMask == 8'h0) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            state_d = ON;
            idx_d   = lowestBit(rlMask);
          end
        end else begin
          state_d = ON;
          idx_d   = nextAbove(actMask_q, idx_q);
        end
      end
    end
  end

  // Output registers follow the scan state one cycle later, which also delays
  // the frame-end flag so the pulse lands on the first dark cycle after the
  // last lit cycle of the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      selOut_q    <= 3'd0;
      digOut_q    <= 8'h00;
      nibOut_q    <= 4'h0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= pend_q;
      case (state_q)
        ON: begin
          selOut_q <= idx_q;
          digOut_q <= 8'b1 << idx_q;
          nibOut_q <= actData_q[{idx_q, 2'b00} +: 4];
        end
        BLANK: begin
          selOut_q <= idx_q;
          digOut_q <= 8'h00;
          nibOut_q <= 4'h0;
        end
        default: begin
          selOut_q <= 3'd0;
          digOut_q <= 8'h00;
          nibOut_q <= 4'h0;
        end
      endcase
    end
  end

  assign sel_o        = selOut_q;
  assign dig_o        = digOut_q;
  assign nib_o        = nibOut_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl. Two instances run side by side:
//   dutA with SCAN_DIV=4, BLANK_CYC=2 and dutB with SCAN_DIV=4, BLANK_CYC=0.
//   A behavioural model describes the scan as a position inside a digit period
//   and is compared against both instances on every falling edge, alongside
//   directed checks and randomized stimulus.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int SCAN   = 4;
  localparam int BLANKA = 2;
  localparam int BLANKB = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enA, loadA, enB, loadB;
  logic [7:0]  maskA, maskB;
  logic [31:0] dataA, dataB;
  logic [2:0]  selA, selB;
  logic [7:0]  digA, digB;
  logic [3:0]  nibA, nibB;
  logic        fdA, fdB;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 1'b0;

  typedef struct {
    bit          run;
    int          digit;
    int          phase;
    logic [31:0] actData;
    logic [7:0]  actMask;
    logic [31:0] shData;
    logic [7:0]  shMask;
    bit          fdPend;
    logic [7:0]  eDig;
    logic [3:0]  eNib;
    logic [2:0]  eSel;
    logic        eFd;
  } model_t;

  model_t mA, mB;

  seg_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLANKA)) dutA (
    .clk_i(clk), .rst_i(rst), .en_i(enA), .dig_en_i(maskA), .data_i(dataA),
    .load_i(loadA), .sel_o(selA), .dig_o(digA), .nib_o(nibA), .frame_done_o(fdA)
  );

  seg_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLANKB)) dutB (
    .clk_i(clk), .rst_i(rst), .en_i(enB), .dig_en_i(maskB), .data_i(dataB),
    .load_i(loadB), .sel_o(selB), .dig_o(digB), .nib_o(nibB), .frame_done_o(fdB)
  );

  always #5 clk = ~clk;

  function automatic int lowestOf(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int highestOf(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int nextOf(input logic [7:0] m, input int d);
    for (int i = d + 1; i < 8; i++) if (m[i]) return i;
    return lowestOf(m);
  endfunction

  function automatic model_t modelReset();
    model_t r;
    r.run = 0; r.digit = 0; r.phase = 0;
    r.actData = 32'h0; r.actMask = 8'h0;
    r.shData = 32'h0; r.shMask = 8'hFF;
    r.fdPend = 0;
    r.eDig = 8'h0; r.eNib = 4'h0; r.eSel = 3'd0; r.eFd = 1'b0;
    return r;
  endfunction

  // One clock of the display as seen by a viewer: a digit owns a period of
  // scan+blank cycles, lit for the first scan of them; outputs show the
  // position reached one clock earlier.
  function automatic model_t modelStep(input model_t m, input int scan, input int blank,
                                       input logic en, input logic ld,
                                       input logic [7:0] msk, input logic [31:0] dat);
    model_t r;
    logic [7:0]  rm;
    logic [31:0] rd;
    bit          lit;
    r = m;
    lit    = m.run && (m.phase < scan);
    r.eDig = lit ? 8'(1 << m.digit) : 8'h0;
    r.eNib = lit ? m.actData[m.digit*4 +: 4] : 4'h0;
    r.eSel = m.run ? 3'(m.digit) : 3'd0;
    r.eFd  = m.fdPend;
    r.fdPend = 0;
    rm = ld ? msk : m.shMask;
    rd = ld ? dat : m.shData;
    if (!en) begin
      r.run = 0;
    end else if (!m.run) begin
      if (rm != 8'h0) begin
        r.run = 1; r.actMask = rm; r.actData = rd;
        r.digit = lowestOf(rm); r.phase = 0;
      end
    end else begin
      if (m.phase == scan - 1 && m.digit == highestOf(m.actMask)) r.fdPend = 1;
      r.phase = m.phase + 1;
      if (r.phase == scan + blank) begin
        r.phase = 0;
        if (m.digit == highestOf(m.actMask)) begin
          r.actMask = rm; r.actData = rd;
          if (rm == 8'h0) r.run = 0;
          else r.digit = lowestOf(rm);
        end else begin
          r.digit = nextOf(m.actMask, m.digit);
        end
      end
    end
    if (ld) begin
      r.shMask = msk; r.shData = dat;
    end
    return r;
  endfunction

  // Reference models advance on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA = modelReset();
      mB = modelReset();
    end else begin
      mA = modelStep(mA, SCAN, BLANKA, enA, loadA, maskA, dataA);
      mB = modelStep(mB, SCAN, BLANKB, enB, loadB, maskB, dataB);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare both instances against their models every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("A.dig", 32'(digA), 32'(mA.eDig));
      checkOutput("A.sel", 32'(selA), 32'(mA.eSel));
      checkOutput("A.nib", 32'(nibA), 32'(mA.eNib));
      checkOutput("A.fd",  32'(fdA),  32'(mA.eFd));
      checkOutput("B.dig", 32'(digB), 32'(mB.eDig));
      checkOutput("B.sel", 32'(selB), 32'(mB.eSel));
      checkOutput("B.nib", 32'(nibB), 32'(mB.eNib));
      checkOutput("B.fd",  32'(fdB),  32'(mB.eFd));
    end
  end

  task automatic applyStimulus(input logic e, input logic ld, input logic [7:0] m, input logic [31:0] d);
    @(posedge clk); #1;
    enA = e; loadA = ld; maskA = m; dataA = d;
  endtask

  task automatic startB();
    @(posedge clk); #1;
    enB = 1'b0; loadB = 1'b1; maskB = 8'h08; dataB = $urandom;
    @(posedge clk); #1;
    enB = 1'b1; loadB = 1'b0;
  endtask

  task automatic waitLit(input logic [2:0] s, input int limit, input string tag);
    bit found;
    found = 0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      if (digA == (8'b1 << s)) found = 1;
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic countFd(input int n, output int cA, output int cB);
    cA = 0; cB = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (fdA) cA++;
      if (fdB) cB++;
    end
  endtask

  initial begin
    int  cA, cB;
    bit  badSel;
    enA = 0; loadA = 0; maskA = 8'h0; dataA = 32'h0;
    enB = 0; loadB = 0; maskB = 8'h0; dataB = 32'h0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("rst.dig", 32'(digA), 32'h0);
    checkOutput("rst.fd",  32'(fdA),  32'h0);

    // Full scan of all digits, with the single-digit instance running alongside.
    startB();
    applyStimulus(1'b0, 1'b1, 8'hFF, 32'h76543210);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h76543210);
    repeat (5) @(negedge clk);
    countFd(96, cA, cB);
    checkOutput("full.fdCount", 32'(cA), 32'd2);
    checkOutput("single.fdCount", 32'(cB), 32'd24);

    // Asynchronous reset while digit 2 is lit.
    waitLit(3'd2, 100, "reset.waitDig04");
    #2 rst = 1'b1; enA = 1'b0;
    #1;
    checkOutput("asyncRst.dig", 32'(digA), 32'h0);
    checkOutput("asyncRst.sel", 32'(selA), 32'h0);
    checkOutput("asyncRst.nib", 32'(nibA), 32'h0);
    checkOutput("asyncRst.fd",  32'(fdA),  32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idleAfterRst.dig", 32'(digA), 32'h0);

    // Sparse mask 0 -> 2 -> 7.
    startB();
    applyStimulus(1'b0, 1'b1, 8'h85, $urandom);
    applyStimulus(1'b1, 1'b0, 8'h85, 32'h0);
    repeat (5) @(negedge clk);
    badSel = 0; cA = 0; cB = 0;
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      if (selA == 3'd1 || (selA >= 3'd3 && selA <= 3'd6)) badSel = 1;
      if (fdA) cA++;
      if (fdB) cB++;
    end
    checkOutput("sparse.badSel", 32'(badSel), 32'd0);
    checkOutput("sparse.fdCount", 32'(cA), 32'd4);
    checkOutput("single.fdCount2", 32'(cB), 32'd18);

    // Deferred load: new content only from the next frame's first digit.
    applyStimulus(1'b1, 1'b1, 8'hFF, 32'h76543210);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    waitLit(3'd3, 200, "defer.waitDig3");
    waitLit(3'd2, 200, "defer.waitDig2");
    applyStimulus(1'b1, 1'b1, 8'hFF, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    waitLit(3'd7, 100, "defer.waitDig7");
    checkOutput("defer.oldNib7", 32'(nibA), 32'h7);
    waitLit(3'd0, 100, "defer.waitDig0");
    checkOutput("defer.newNib0", 32'(nibA), 32'hF);

    // Empty mask ends the scan after one more frame_done.
    applyStimulus(1'b1, 1'b1, 8'h00, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);
    countFd(80, cA, cB);
    checkOutput("mask0.fdCount", 32'(cA), 32'd1);
    checkOutput("mask0.dig", 32'(digA), 32'h0);

    // Abort during digit 5, then restart at digit 0.
    applyStimulus(1'b1, 1'b1, 8'hFF, 32'h76543210);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    waitLit(3'd5, 100, "abort.waitDig5");
    applyStimulus(1'b0, 1'b0, 8'hFF, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("abort.dig", 32'(digA), 32'h0);
    countFd(30, cA, cB);
    checkOutput("abort.fdCount", 32'(cA), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("restart.dig", 32'(digA), 32'h01);
    checkOutput("restart.sel", 32'(selA), 32'h0);

    // Randomized enables, loads, masks and data.
    for (int k = 0; k < 1500; k++) begin
      applyStimulus(($urandom_range(0, 19) != 0),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom),
                    $urandom);
    end
    repeat (2) @(negedge clk);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
